mem_arbiter: RTL and testbench

- Shares the single-port 1K x 16 main memory between NUM_REQ requesters: CPU instruction fetch, CPU data access, and an I/O/DMA port.
- Uses round-robin arbitration with a bounded lock for read-modify-write sequences.
- Sits between the requesters and the memory. The top level converts the split mem_wdata/mem_rdata pair onto the memory's bidirectional data port.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_rr_picker.sv | 32 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM encodings, default bus widths
// and the index-to-one-hot helper used to form grant vectors.
package mem_arb_pkg;

  localparam int AW_DEF  = 10;
  localparam int DW_DEF  = 16;
  localparam int MAX_REQ = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RDATA  = 2'd2;

  function automatic logic [MAX_REQ-1:0] idx2oh(input int unsigned idx);
    idx2oh = MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: flattened per-requester request
// fields in, one-hot grant/read-valid pulses and shared read data out.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ*DW-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [DW-1:0]         rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      winner_o,
  output logic               found_o
);

  always_comb begin
    int          idx;
    logic        hit;
    logic [IW-1:0] win;
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && req_i[idx]) begin
        hit = 1'b1;
        win = IW'(idx);
      end
    end
    winner_o = win;
    found_o  = hit;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded read-modify-write lock, sharing one
// single-port memory between NUM_REQ requesters (IDLE -> ACCESS [-> RDATA]).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               owner_vld_q, owner_vld_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_re_q, mem_re_d;

  logic [IW-1:0] rr_winner;
  logic          any_req;
  logic          lock_win;
  logic          limit_hit;
  logic [IW-1:0] sel;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req_i    (bus.req),
    .ptr_i    (rr_ptr_q),
    .winner_o (rr_winner),
    .found_o  (any_req)
  );

  // An exhausted lock (cnt == MAX_LOCK) forces one plain round-robin decision.
  assign lock_win  = owner_vld_q && bus.req[owner_q] && (lock_cnt_q < CW'(MAX_LOCK));
  assign limit_hit = owner_vld_q && (lock_cnt_q >= CW'(MAX_LOCK));
  assign sel       = lock_win ? owner_q : rr_winner;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (owner_vld_q && !bus.req[owner_q]) begin
          owner_vld_d = 1'b0;
          lock_cnt_d  = '0;
        end
        if (any_req) begin
          state_d     = ST_ACCESS;
          gnt_d       = NUM_REQ'(idx2oh(32'(sel)));
          mem_addr_d  = bus.addr[sel*AW +: AW];
          mem_wdata_d = bus.wdata[sel*DW +: DW];
          mem_we_d    = bus.we[sel];
          mem_re_d    = !bus.we[sel];
          rr_ptr_d    = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
          if (bus.lock[sel] && !limit_hit) begin
            owner_vld_d = 1'b1;
            owner_d     = sel;
            lock_cnt_d  = (owner_vld_q && owner_q == sel) ? lock_cnt_q + CW'(1) : CW'(1);
          end else begin
            owner_vld_d = 1'b0;
            lock_cnt_d  = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_RDATA;
          rvalid_d = gnt_q;
        end
      end
      ST_RDATA: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = (|rvalid_q) ? mem_rdata : '0;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1K x 16 memory behind it;
// inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 3;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(NR), .AW(AW), .DW(DW)) bus ();

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.rvalid) || ((|bus.gnt) && (|bus.rvalid)) ||
          (mem_we && mem_re) || (bus.rvalid == '0 && bus.rdata != '0)) begin
        errors++;
        $display("FAIL invariant: gnt=%b rvalid=%b mem_we=%b mem_re=%b rdata=%h", bus.gnt,
                 bus.rvalid, mem_we, mem_re, bus.rdata);
      end
    end
  end

  task automatic clear_reqs();
    bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic lk, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req[i] = 1'b1;
    bus.we[i] = w;
    bus.lock[i] = lk;
    bus.addr[i*AW +: AW] = a;
    bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic next_grant(input int budget, output logic [NR-1:0] g, output int waited);
    g = '0;
    waited = 0;
    while (g == '0 && waited < budget) begin
      @(negedge clk);
      waited++;
      g = bus.gnt;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000) begin
      errors++; $display("FAIL reset_gnt_rvalid: got %b/%b expected 000/000", bus.gnt, bus.rvalid);
    end
    checks++;
    if (bus.rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0000", bus.rdata);
    end
    checks++;
    if ({mem_we, mem_re} !== 2'b00 || mem_addr !== 10'h000 || mem_wdata !== 16'h0000) begin
      errors++; $display("FAIL reset_mem: got we=%b re=%b addr=%h wdata=%h expected all 0",
                         mem_we, mem_re, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 10'h005, 16'h0000);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b001 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h005) begin
      errors++; $display("FAIL read_grant: got gnt=%b re=%b we=%b addr=%h expected 001/1/0/005",
                         bus.gnt, mem_re, mem_we, mem_addr);
    end
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 3'b001 || bus.rdata !== 16'hBEEF) begin
      errors++; $display("FAIL read_data: got rvalid=%b rdata=%h expected 001/beef",
                         bus.rvalid, bus.rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 3'b000 || bus.rdata !== 16'h0000) begin
      errors++; $display("FAIL read_done: got rvalid=%b rdata=%h expected 000/0000",
                         bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_single_write();
    set_req(1, 1'b1, 1'b0, 10'h3FF, 16'h1234);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b010 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 10'h3FF ||
        mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL write_grant: got gnt=%b we=%b re=%b addr=%h wdata=%h expected 010/1/0/3ff/1234",
                         bus.gnt, mem_we, mem_re, mem_addr, mem_wdata);
    end
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 3'b000 || mem_we !== 1'b0 || bus.gnt !== 3'b000) begin
      errors++; $display("FAIL write_no_rvalid: got rvalid=%b we=%b gnt=%b expected 000/0/000",
                         bus.rvalid, mem_we, bus.gnt);
    end
    set_req(1, 1'b0, 1'b0, 10'h3FF, 16'h0000);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b010 || mem_re !== 1'b1) begin
      errors++; $display("FAIL write_next_grant: got gnt=%b re=%b expected 010/1", bus.gnt, mem_re);
    end
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 3'b010 || bus.rdata !== 16'h1234) begin
      errors++; $display("FAIL write_readback: got rvalid=%b rdata=%h expected 010/1234",
                         bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [6];
    logic [NR-1:0] g;
    int w;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    set_req(0, 1'b0, 1'b0, 10'h010, 16'h0);
    set_req(1, 1'b0, 1'b0, 10'h020, 16'h0);
    set_req(2, 1'b0, 1'b0, 10'h030, 16'h0);
    for (int k = 0; k < 6; k++) begin
      next_grant(10, g, w);
      checks++;
      if (g !== exp_g[k]) begin
        errors++; $display("FAIL rr_order[%0d]: got %b expected %b", k, g, exp_g[k]);
      end
      if (k > 0) begin
        checks++;
        if (w != 3) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", k, w);
        end
      end
    end
    clear_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lock_limit();
    logic [NR-1:0] exp_g [10];
    logic [NR-1:0] g;
    int w;
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
              3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
    do_reset();
    set_req(0, 1'b0, 1'b1, 10'h040, 16'h0);
    set_req(2, 1'b0, 1'b0, 10'h050, 16'h0);
    for (int k = 0; k < 10; k++) begin
      next_grant(10, g, w);
      checks++;
      if (g !== exp_g[k]) begin
        errors++; $display("FAIL lock_order[%0d]: got %b expected %b", k, g, exp_g[k]);
      end
    end
    clear_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [NR-1:0] g;
    int w;
    logic stray;
    do_reset();
    set_req(1, 1'b0, 1'b0, 10'h3FF, 16'h0);
    next_grant(10, g, w);
    checks++;
    if (g !== 3'b010) begin
      errors++; $display("FAIL rst_pre_grant: got %b expected 010", g);
    end
    rst_n = 1'b0;
    set_req(2, 1'b0, 1'b0, 10'h005, 16'h0);
    #1;
    checks++;
    if (mem_re !== 1'b0 || bus.gnt !== 3'b000 || bus.rvalid !== 3'b000) begin
      errors++; $display("FAIL rst_abort: got re=%b gnt=%b rvalid=%b expected 0/000/000",
                         mem_re, bus.gnt, bus.rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    g = '0;
    w = 0;
    stray = 1'b0;
    while (g == '0 && w < 10) begin
      @(negedge clk);
      w++;
      g = bus.gnt;
      if (bus.rvalid != '0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++; $display("FAIL rst_stray_rvalid: got rvalid seen=%b expected 0", stray);
    end
    checks++;
    if (g !== 3'b010) begin
      errors++; $display("FAIL rst_first_grant: got %b expected 010", g);
    end
    clear_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_request_withdrawn();
    logic [NR-1:0] g;
    int w;
    logic stray;
    do_reset();
    set_req(0, 1'b0, 1'b0, 10'h005, 16'h0);
    next_grant(10, g, w);
    clear_reqs();
    set_req(2, 1'b0, 1'b0, 10'h030, 16'h0);
    @(negedge clk);
    clear_reqs();
    set_req(1, 1'b0, 1'b0, 10'h3FF, 16'h0);
    next_grant(10, g, w);
    checks++;
    if (g !== 3'b010) begin
      errors++; $display("FAIL withdrawn_grant: got %b expected 010", g);
    end
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 3'b010 || bus.rdata !== 16'h1234) begin
      errors++; $display("FAIL withdrawn_rdata: got rvalid=%b rdata=%h expected 010/1234",
                         bus.rvalid, bus.rdata);
    end
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.gnt != '0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++; $display("FAIL withdrawn_stray: got late grant seen=%b expected 0", stray);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA500;
    mem[5] = 16'hBEEF;
    clear_reqs();
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_lock_limit();
    test_reset_mid_read();
    test_request_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
